// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame sizing and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop
  } uart_state_e;

  // Bits on the line for one frame: start + data + optional parity + stop bits.
  function automatic int unsigned frame_bits(int unsigned data_width, int unsigned parity,
                                             int unsigned stop_bits);
    return 1 + data_width + parity + stop_bits;
  endfunction

  localparam int unsigned UartFrameBits = frame_bits(8, 1, 1);

  // Parity bit for zero-extended data: even=1 makes data+parity hold an even count of ones.
  function automatic logic parity_calc(logic [31:0] data, logic even);
    return even ? (^data) : ~(^data);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input, with a configurable reset value.
module uart_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,  // synchronous, active low
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; resets to the line's idle level.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing, mid-bit sampling, one-cycle word strobe.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around mid-bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY     = 1,
  parameter int unsigned EVEN       = 1,
  parameter int unsigned PRESCALER  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rxd,
  output logic                  rxv,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  active
);

  localparam int unsigned PskW   = $clog2(PRESCALER);
  localparam int unsigned BitMax = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
  localparam int unsigned BitW   = $clog2(BitMax + 1);
  localparam int unsigned Mid    = (PRESCALER - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned TickAt = Mid + 1;
`else
  localparam int unsigned TickAt = Mid;
`endif

  logic rx_s;

  uart_sync #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  uart_state_e           state_q, state_d;
  logic [PskW-1:0]       psk_q, psk_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_acc_q, par_acc_d;
  logic                  perr_acc_q, perr_acc_d;
  logic                  ferr_acc_q, ferr_acc_d;
  logic                  armed_q, armed_d;
  logic [DATA_WIDTH-1:0] rxd_q, rxd_d;
  logic                  rxv_q, rxv_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  active_q, active_d;

  logic tick;
  logic sample;
  logic ferr_next;

  assign tick = (state_q != StIdle) && (psk_q == PskW'(TickAt));

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q, vote_d;

  // Capture the two samples preceding the decision point.
  always_comb begin
    vote_d = vote_q;
    if (psk_q == PskW'(Mid - 1)) vote_d[0] = rx_s;
    if (psk_q == PskW'(Mid))     vote_d[1] = rx_s;
  end

  // Voter history register.
  always_ff @(posedge clk) begin
    if (!rst) vote_q <= 2'b11;
    else      vote_q <= vote_d;
  end

  assign sample = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
  assign sample = rx_s;
`endif

  // Next-state: prescaler, bit counter, FSM, shifter and registered outputs.
  always_comb begin
    state_d    = state_q;
    psk_d      = psk_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    armed_d    = armed_q;
    rxd_d      = rxd_q;
    rxv_d      = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    active_d   = active_q;
    ferr_next  = ferr_acc_q | ~sample;

    // Free-running bit-period counter while a frame is in progress.
    if (state_q != StIdle) begin
      psk_d = (psk_q == PskW'(PRESCALER - 1)) ? '0 : psk_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_s) armed_d = 1'b1;
        // armed_q implies rx_s was seen high, so a low rx_s here is a falling edge.
        if (armed_q && !rx_s) begin
          state_d    = StStart;
          psk_d      = '0;
          bit_d      = '0;
          par_acc_d  = 1'b0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
          active_d   = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          if (sample) begin
            state_d  = StIdle;
            active_d = 1'b0;
          end else begin
            state_d = StData;
            bit_d   = '0;
          end
        end
      end
      StData: begin
        if (tick) begin
          shift_d   = {sample, shift_q[DATA_WIDTH-1:1]};
          par_acc_d = par_acc_q ^ sample;
          if (bit_q == BitW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? StPar : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StPar: begin
        if (tick) begin
          perr_acc_d = sample != parity_calc(32'(par_acc_q), EVEN != 0);
          state_d    = StStop;
        end
      end
      StStop: begin
        if (tick) begin
          if (bit_q == BitW'(STOP_BITS - 1)) begin
            state_d  = StIdle;
            rxv_d    = 1'b1;
            rxd_d    = shift_q;
            perr_d   = perr_acc_q;
            ferr_d   = ferr_next;
            active_d = 1'b0;
            // A bad stop bit may be a break: wait for the line to go high before rearming.
            if (ferr_next) armed_d = 1'b0;
          end else begin
            ferr_acc_d = ferr_next;
            bit_d      = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      psk_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      armed_q    <= 1'b0;
      rxd_q      <= '0;
      rxv_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      psk_q      <= psk_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      armed_q    <= armed_d;
      rxd_q      <= rxd_d;
      rxv_q      <= rxv_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      active_q   <= active_d;
    end
  end

  assign rxd        = rxd_q;
  assign rxv        = rxv_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign active     = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 8 data bits, even parity, 1 stop bit, 15 clocks per bit.
module tb_uart_rx;

  localparam int unsigned P  = 15;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx  = 1'b1;
  logic [DW-1:0] rxd;
  logic          rxv;
  logic          parity_err;
  logic          frame_err;
  logic          active;

  uart_rx #(
    .DATA_WIDTH(DW),
    .STOP_BITS (1),
    .PARITY    (1),
    .EVEN      (1),
    .PRESCALER (P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rxd       (rxd),
    .rxv       (rxv),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .active    (active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned rxv_time[$];
  int unsigned cyc = 0;
  int          rxv_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        active_seen = 1'b0;
  int          base;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop the expected word on every strobe.
  always @(negedge clk) begin
    if (active === 1'b1) active_seen = 1'b1;
    if (rxv === 1'b1) begin
      rxv_cnt++;
      rxv_time.push_back(cyc);
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rxv: got strobe with rxd=%0h, expected none", rxd);
      end else begin
        mon_e = sb_q.pop_front();
        check("rxd", 32'(rxd), 32'(mon_e.d));
        check("parity_err", 32'(parity_err), 32'(mon_e.pe));
        check("frame_err", 32'(frame_err), 32'(mon_e.fe));
      end
    end
  end

  task automatic expect_word(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    sb_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (P) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

`ifdef UART_RX_MAJORITY_EN
  // Each bit carries a one-cycle inverted spike at its middle.
  task automatic send_bit_spiky(input logic b);
    rx = b;
    repeat (7) @(negedge clk);
    rx = ~b;
    @(negedge clk);
    rx = b;
    repeat (P - 8) @(negedge clk);
  endtask

  task automatic send_frame_spiky(input logic [7:0] d, input logic par);
    send_bit_spiky(1'b0);
    for (int i = 0; i < 8; i++) send_bit_spiky(d[i]);
    send_bit_spiky(par);
    send_bit_spiky(1'b1);
  endtask
`endif

  task automatic wait_rxv(input int target, input int budget);
    int n = 0;
    while (rxv_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("rxv_count", 32'(rxv_cnt), 32'(target));
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rxd", 32'(rxd), 32'h0);
    check("reset_rxv", 32'(rxv), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_active", 32'(active), 32'h0);
    rst = 1'b1;
    repeat (2 * P) @(negedge clk);

    // 1: 0xA5 has four ones, even parity bit 0.
    expect_word(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_rxv(1, 50);

    // 2: 0x01 needs parity 1; send 0.
    expect_word(8'h01, 1'b1, 1'b0);
    send_frame(8'h01, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_rxv(2, 50);

    // 3: bad stop bit followed by a 40-bit-time break.
    expect_word(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40 * P) @(negedge clk);
    check("break_rxv_count", 32'(rxv_cnt), 32'd3);
    check("break_active", 32'(active), 32'h0);
    repeat (3) send_bit(1'b1);
    expect_word(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_rxv(4, 50);

    // 4: three-cycle low glitch on an idle line.
    active_seen = 1'b0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * P) @(negedge clk);
    check("glitch_active_seen", 32'(active_seen), 32'h1);
    check("glitch_active_end", 32'(active), 32'h0);
    check("glitch_rxv_count", 32'(rxv_cnt), 32'd4);
    check("glitch_rxd_held", 32'(rxd), 32'h5A);
    check("glitch_frame_err", 32'(frame_err), 32'h0);

    // 5: reset in the middle of data bit 3 of 0x55.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_active", 32'(active), 32'h0);
    check("midreset_rxd", 32'(rxd), 32'h0);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3 * P) @(negedge clk);
    check("midreset_rxv_count", 32'(rxv_cnt), 32'd4);
    expect_word(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_rxv(5, 50);

    // 6: back-to-back frames, 11 bits each.
    base = rxv_time.size();
    expect_word(8'h00, 1'b0, 1'b0);
    expect_word(8'hFF, 1'b0, 1'b0);
    expect_word(8'h81, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_rxv(8, 50);
    if (rxv_time.size() >= base + 3) begin
      check("b2b_spacing_1", rxv_time[base+1] - rxv_time[base], 32'd165);
      check("b2b_spacing_2", rxv_time[base+2] - rxv_time[base+1], 32'd165);
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL b2b_spacing: got %0d strobes, expected %0d", rxv_time.size() - base, 3);
    end

`ifdef UART_RX_MAJORITY_EN
    expect_word(8'h00, 1'b0, 1'b0);
    expect_word(8'hFF, 1'b0, 1'b0);
    expect_word(8'h81, 1'b0, 1'b0);
    send_frame_spiky(8'h00, 1'b0);
    send_frame_spiky(8'hFF, 1'b0);
    send_frame_spiky(8'h81, 1'b0);
    send_bit(1'b1);
    wait_rxv(11, 50);
`endif

    repeat (P) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
